branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
Sequencing controller for the shared branch comparator in the EX stage of the rv32 pipeline.
- Accepts one conditional-branch operation at a time from ID/EX and drives the comparator's unsigned-select.
- Samples the comparator's equal/less-than results and decides taken/not-taken from funct3.
- On a taken branch, issues a one-cycle PC redirect followed by a programmable flush window for the younger pipeline stages; also keeps saturating branch statistics.

Parameters:
FLUSH_CYCLES, 2, number of cycles o_flush stays high after a redirect (1..7)
CNT_W, 16, width of the statistics counters

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  reset, synchronous, active-high
i_br_valid  input  1  branch op offered by ID/EX
o_br_ready  output  1  controller can accept an op this cycle
i_funct3  input  3  RV32I branch funct3
i_pc  input  32  PC of the branch instruction
i_target  input  32  precomputed branch target (pc + imm)
i_stall  input  1  pipeline stall; freezes controller state
o_brUn  output  1  unsigned-compare select to comparator
i_brEq  input  1  comparator equal result
i_brLT  input  1  comparator less-than result
o_redirect  output  1  one-cycle PC redirect strobe
o_redirect_pc  output  32  new PC, valid while o_redirect=1
o_flush  output  1  squash IF/ID and ID/EX contents
o_resolved  output  1  one-cycle pulse: branch resolved (taken or not)
o_taken  output  1  qualifies o_resolved: 1 = taken
o_illegal  output  1  one-cycle pulse: funct3 010/011 seen
o_misalign  output  1  one-cycle pulse: taken target with target[1:0] != 0
o_br_count  output  CNT_W  resolved branches, saturating
o_taken_count  output  CNT_W  taken branches, saturating

Behaviour:
- Reset: state IDLE. Every output is 0 and both counters are 0; o_br_ready=0 during reset.
- Reset asserted mid-operation aborts the branch: no redirect or flush is issued afterwards, and counters clear.
- States are IDLE, RESOLVE, REDIRECT, FLUSH.
- IDLE:
  - o_br_ready=1 when !i_stall.
  - Accept when i_br_valid && o_br_ready: latch funct3, pc and target, then go to RESOLVE.
  - Illegal funct3 (010, 011): pulse o_illegal next cycle, stay IDLE, no count update, no redirect.
- RESOLVE:
  - o_br_ready=0; o_brUn = latched funct3[1].
  - i_brEq/i_brLT are sampled at the end of this cycle.
  - taken: BEQ(000)=Eq, BNE(001)=!Eq, BLT(100)/BLTU(110)=LT, BGE(101)/BGEU(111)=!LT.
  - Next cycle: o_resolved=1, o_taken=taken; o_br_count increments.
  - Not taken: return to IDLE.
  - Taken with target[1:0]==0: o_taken_count increments, go to REDIRECT.
  - Taken with target[1:0]!=0: o_misalign pulses instead of a redirect, o_taken_count increments, return to IDLE.
- REDIRECT: o_redirect=1 and o_redirect_pc=latched target for exactly one cycle; go to FLUSH.
- FLUSH:
  - o_flush=1 for FLUSH_CYCLES cycles, tracked by an internal down-counter; then return to IDLE.
  - o_br_ready goes high in the cycle after the last flush cycle.
- Latency: accept at cycle N, resolve pulse at N+2, redirect at N+2 (same cycle as o_resolved), flush from N+3 to N+2+FLUSH_CYCLES.
- Stall:
  - While i_stall=1 in RESOLVE or FLUSH, the state and flush counter hold. Comparator sampling is deferred to the first unstalled RESOLVE cycle.
  - REDIRECT is never stalled: the redirect strobe is not repeated.
  - Pulses (o_resolved, o_illegal, o_misalign) are never repeated while stalled.
- o_brUn holds its last value outside RESOLVE.
- Counters saturate at all-ones; they do not wrap.
- Back-to-back: a new op offered during RESOLVE, REDIRECT or FLUSH is not accepted (o_br_ready=0). The requester holds i_br_valid.

Decomposition:
- Package branch_pkg holds:
  - funct3 constants: F3_BEQ=000, F3_BNE=001, F3_BLT=100, F3_BGE=101, F3_BLTU=110, F3_BGEU=111.
  - State encoding: IDLE=0, RESOLVE=1, REDIRECT=2, FLUSH=3 (2 bits).
- One combinational sub-module, branch_cond: inputs funct3, Eq, LT; outputs taken and illegal. Also reused by the decoder for static prediction.
- Counters and the state machine stay in branch_ctrl.

Test Plan:
- Setup for all scenarios: FLUSH_CYCLES=2, CNT_W=16.
- Reset: hold i_rst=1 for 2 cycles with i_br_valid=1 -> all outputs 0, counters 0, no accept; o_br_ready=1 in the first cycle after release.
- BEQ taken: funct3=000, target=0x0000_0100, Eq=1 in RESOLVE -> o_brUn=0; o_resolved=o_taken=1 and o_redirect=1, pc=0x100 at N+2; o_flush at N+3..N+4; o_br_ready=1 at N+5; both counts=1.
- BLTU not taken: funct3=110, LT=0 -> o_brUn=1 in RESOLVE; o_resolved=1, o_taken=0; no redirect or flush; o_br_count=1, o_taken_count=0; ready again at N+2.
- Illegal and misalign cases:
  - funct3=011 -> o_illegal pulse at N+1, counters unchanged.
  - BNE taken, target=0x0000_0102 -> o_misalign pulse, no o_redirect, o_taken_count increments.
- Stall: assert i_stall for 3 cycles in RESOLVE, then Eq changes to 1 -> resolution uses the post-stall Eq; single o_resolved pulse. Stall of 2 cycles in FLUSH -> o_flush high for 4 cycles total.
- Saturation and abort:
  - Force o_br_count to 0xFFFF via 65535 branches (or a fast-sim preload), then one more -> stays 0xFFFF.
  - Assert i_rst in REDIRECT -> no o_flush afterwards, state IDLE.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage branch controller.
// funct3 codes for conditional branches and controller state encoding.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESOLVE  = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } brState_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode from funct3 and comparator flags.
// Shared with the decoder for static prediction.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       eq,
  input  logic       lt,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      (funct3 == F3_BEQ):  taken = eq;
      (funct3 == F3_BNE):  taken = !eq;
      (funct3 == F3_BLT):  taken = lt;
      (funct3 == F3_BGE):  taken = !lt;
      (funct3 == F3_BLTU): taken = lt;
      (funct3 == F3_BGEU): taken = !lt;
      default:             illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch sequencer: resolve, redirect, flush window,
// plus saturating branch statistics.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_br_valid,
  output logic             o_br_ready,
  input  logic [2:0]       i_funct3,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_target,
  input  logic             i_stall,
  output logic             o_brUn,
  input  logic             i_brEq,
  input  logic             i_brLT,
  output logic             o_redirect,
  output logic [31:0]      o_redirect_pc,
  output logic             o_flush,
  output logic             o_resolved,
  output logic             o_taken,
  output logic             o_illegal,
  output logic             o_misalign,
  output logic [CNT_W-1:0] o_br_count,
  output logic [CNT_W-1:0] o_taken_count
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  brState_e         state, stateNext;
  logic [2:0]       funct3Q, condF3, flushCnt;
  logic [31:0]      pcQ, targetQ;
  logic             brUnQ, resolvedQ, takenQ;
  logic             illegalQ, misalignQ;
  logic [CNT_W-1:0] brCnt, takenCnt;
  logic             condTaken, condIllegal;
  logic             ready, accept, resolveNow;
  logic             illegalNext, misalignNext;
  logic             unusedPc;

  function automatic logic [CNT_W-1:0] satInc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // One decoder: legality on the offered op, outcome on the latched one
  assign condF3 = (state == IDLE) ? i_funct3 : funct3Q;

  branch_cond uCond (
    .funct3  (condF3),
    .eq      (i_brEq),
    .lt      (i_brLT),
    .taken   (condTaken),
    .illegal (condIllegal)
  );

  assign ready    = (state == IDLE) && !i_stall && !i_rst;
  assign accept   = i_br_valid && ready;
  assign unusedPc = ^pcQ;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    resolveNow   = 1'b0;
    illegalNext  = 1'b0;
    misalignNext = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (condIllegal) illegalNext = 1'b1;
          else             stateNext   = RESOLVE;
        end
      end
      RESOLVE: begin
        if (!i_stall) begin
          resolveNow = 1'b1;
          stateNext  = IDLE;
          if (condTaken) begin
            if (targetQ[1:0] == 2'b00) stateNext = REDIRECT;
            else                       misalignNext = 1'b1;
          end
        end
      end
      REDIRECT: stateNext = FLUSH;
      FLUSH: begin
        if (!i_stall && flushCnt == 3'd0) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      funct3Q   <= '0;
      pcQ       <= '0;
      targetQ   <= '0;
      brUnQ     <= 1'b0;
      flushCnt  <= '0;
      resolvedQ <= 1'b0;
      takenQ    <= 1'b0;
      illegalQ  <= 1'b0;
      misalignQ <= 1'b0;
      brCnt     <= '0;
      takenCnt  <= '0;
    end else begin
      resolvedQ <= resolveNow;
      takenQ    <= resolveNow && condTaken;
      illegalQ  <= illegalNext;
      misalignQ <= misalignNext;
      if (accept && !condIllegal) begin
        funct3Q <= i_funct3;
        pcQ     <= i_pc;
        targetQ <= i_target;
        brUnQ   <= i_funct3[1];
      end
      if (state == REDIRECT)
        flushCnt <= FLUSH_LOAD;
      else if (state == FLUSH && !i_stall && flushCnt != 3'd0)
        flushCnt <= flushCnt - 3'd1;
      if (resolveNow) begin
        brCnt <= satInc(brCnt);
        if (condTaken) takenCnt <= satInc(takenCnt);
      end
    end
  end

  assign o_br_ready    = ready;
  assign o_brUn        = brUnQ;
  assign o_redirect    = (state == REDIRECT);
  assign o_redirect_pc = o_redirect ? targetQ : 32'h0;
  assign o_flush       = (state == FLUSH);
  assign o_resolved    = resolvedQ;
  assign o_taken       = takenQ;
  assign o_illegal     = illegalQ;
  assign o_misalign    = misalignQ;
  assign o_br_count    = brCnt;
  assign o_taken_count = takenCnt;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl; a 2-bit-counter twin shares
// the stimulus to exercise counter saturation quickly.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst, valid, stall, eq, lt;
  logic [2:0]  f3;
  logic [31:0] pc, target;

  logic        ready, brUn, redirect, flush;
  logic        resolved, taken, illegal, misalign;
  logic [31:0] redirectPc;
  logic [15:0] brCount, takenCount;

  logic        sReady, sBrUn, sRedirect, sFlush;
  logic        sResolved, sTaken, sIllegal, sMisalign;
  logic [31:0] sRedirectPc;
  logic [1:0]  sBrCount, sTakenCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_br_valid(valid),
    .o_br_ready(ready), .i_funct3(f3), .i_pc(pc),
    .i_target(target), .i_stall(stall), .o_brUn(brUn),
    .i_brEq(eq), .i_brLT(lt), .o_redirect(redirect),
    .o_redirect_pc(redirectPc), .o_flush(flush),
    .o_resolved(resolved), .o_taken(taken),
    .o_illegal(illegal), .o_misalign(misalign),
    .o_br_count(brCount), .o_taken_count(takenCount)
  );

  branch_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) dutSat (
    .i_clk(clk), .i_rst(rst), .i_br_valid(valid),
    .o_br_ready(sReady), .i_funct3(f3), .i_pc(pc),
    .i_target(target), .i_stall(stall), .o_brUn(sBrUn),
    .i_brEq(eq), .i_brLT(lt), .o_redirect(sRedirect),
    .o_redirect_pc(sRedirectPc), .o_flush(sFlush),
    .o_resolved(sResolved), .o_taken(sTaken),
    .o_illegal(sIllegal), .o_misalign(sMisalign),
    .o_br_count(sBrCount), .o_taken_count(sTakenCount)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] f, input logic [31:0] t);
    valid  = 1'b1;
    f3     = f;
    pc     = t - 32'h40;
    target = t;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b1; stall = 1'b0;
    eq = 1'b0; lt = 1'b0; f3 = 3'b000;
    pc = 32'h0; target = 32'h100;

    // reset held two cycles with an op offered
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_ready", ready, 0);
      check("rst_outs", {brUn, redirect, flush, resolved,
                         taken, illegal, misalign}, 0);
      check("rst_pc", redirectPc, 0);
      check("rst_cnt", {brCount, takenCount}, 0);
    end
    rst = 1'b0; valid = 1'b0;
    #1 check("rel_ready", ready, 1);

    // BEQ taken
    offer(3'b000, 32'h100);
    #1 check("beq_acc", ready, 1);
    tick(); valid = 1'b0; eq = 1'b1; lt = 1'b0;
    check("beq_brun", brUn, 0);
    check("beq_busy", ready, 0);
    check("beq_nores", resolved, 0);
    tick(); eq = 1'b0;
    check("beq_res", {resolved, taken, redirect}, 3'b111);
    check("beq_rpc", redirectPc, 32'h100);
    check("beq_nofl", flush, 0);
    tick();
    check("beq_fl1", {flush, redirect, resolved}, 3'b100);
    tick();
    check("beq_fl2", {flush, ready}, 2'b10);
    tick();
    check("beq_done", {flush, ready}, 2'b01);
    check("beq_cnt", {brCount, takenCount}, {16'd1, 16'd1});

    // BLTU not taken
    offer(3'b110, 32'h200);
    tick(); valid = 1'b0; lt = 1'b0; eq = 1'b1;
    check("bltu_brun", brUn, 1);
    tick(); eq = 1'b0;
    check("bltu_res", {resolved, taken, redirect, flush}, 4'b1000);
    check("bltu_rdy", ready, 1);
    check("bltu_cnt", {brCount, takenCount}, {16'd2, 16'd1});
    tick();
    check("bltu_quiet", {resolved, redirect, flush}, 0);

    // illegal funct3
    offer(3'b011, 32'h300);
    #1 check("ill_acc", ready, 1);
    tick(); valid = 1'b0;
    check("ill_pulse", {illegal, ready, resolved}, 3'b110);
    check("ill_brun", brUn, 1);
    tick();
    check("ill_once", {illegal, resolved, redirect}, 0);
    check("ill_cnt", {brCount, takenCount}, {16'd2, 16'd1});

    // BNE taken to a misaligned target
    offer(3'b001, 32'h102);
    tick(); valid = 1'b0; eq = 1'b0;
    check("bne_brun", brUn, 0);
    tick();
    check("mis_res", {resolved, taken, misalign, redirect},
          4'b1110);
    check("mis_cnt", {brCount, takenCount}, {16'd3, 16'd2});
    tick();
    check("mis_once", {misalign, flush, redirect}, 0);

    // stall 3 cycles in RESOLVE, Eq rises afterwards
    offer(3'b000, 32'h300);
    tick(); valid = 1'b0; stall = 1'b1; eq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stl_hold", {resolved, redirect}, 0);
    end
    stall = 1'b0; eq = 1'b1;
    tick(); eq = 1'b0;
    check("stl_res", {resolved, taken, redirect}, 3'b111);
    check("stl_rpc", redirectPc, 32'h300);
    tick(); stall = 1'b1;
    check("stl_once", resolved, 0);
    // stall 2 cycles in FLUSH: window stretches to 4
    for (int i = 0; i < 4; i++) begin
      check("stl_flush", flush, 1);
      tick();
      if (i == 1) stall = 1'b0;
    end
    check("stl_fl_end", {flush, ready}, 2'b01);
    check("stl_cnt", {brCount, takenCount}, {16'd4, 16'd3});
    check("sat_br", sBrCount, 2'd3);

    // taken branch, then reset while redirecting
    offer(3'b101, 32'h400);
    tick(); valid = 1'b0; lt = 1'b0;
    tick();
    check("abt_redir", redirect, 1);
    check("abt_cnt", {brCount, takenCount}, {16'd5, 16'd4});
    check("sat_both", {sBrCount, sTakenCount}, 4'b1111);
    rst = 1'b1;
    tick(); rst = 1'b0;
    check("abt_clear", {flush, redirect, brCount, takenCount}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abt_noflush", {flush, redirect}, 0);
      check("abt_idle", ready, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
